// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release strobes.
// Optional long-press strobe enabled by defining BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          s;

    // Sync flops reset to the released raw level so reset itself never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned LW = $clog2(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          ldone_q, ldone_d;
    logic          long_q, long_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt_q  <= '0;
            ldone_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            lcnt_q  <= lcnt_d;
            ldone_q <= ldone_d;
            long_q  <= long_d;
        end
    end

    // Counter saturates at LONG_LAST; ldone keeps the strobe to one per press.
    always_comb begin
        lcnt_d  = lcnt_q;
        ldone_d = ldone_q;
        long_d  = 1'b0;
        if (state_q == PRESS_WAIT && state_d == PRESSED) begin
            lcnt_d  = '0;
            ldone_d = 1'b0;
        end else if (state_q == PRESSED) begin
            if (lcnt_q == LONG_LAST) begin
                if (!ldone_q) begin
                    long_d  = 1'b1;
                    ldone_d = 1'b1;
                end
            end else begin
                lcnt_d = lcnt_q + 1'b1;
            end
        end
        if (state_d == IDLE) begin
            lcnt_d  = '0;
            ldone_d = 1'b0;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized + directed bench for button_debounce against a run-length reference model.
// Long-press expectations follow BUTTON_DEBOUNCE_LONG_PRESS_EN when defined.
module tb_button_debounce;

    localparam int D  = 4;
    localparam int L  = 10;
    localparam bit AL = 1'b1;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level, press_pulse, release_pulse, long_press;

    button_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: raw pin delayed two samples; level flips after D consecutive opposite samples.
    bit m_p1, m_p2;
    bit m_level;
    int m_run;
    int m_hold;
    bit e_press, e_release, e_long;
    int press_seen = 0, release_seen = 0, long_seen = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit b, r, s, in_pressed;
        b = btn_in;
        r = rst;
        @(posedge clk);
        e_press = 0;
        e_release = 0;
        e_long = 0;
        if (r) begin
            m_p1 = AL;
            m_p2 = AL;
            m_level = 0;
            m_run = 0;
            m_hold = 0;
        end else begin
            s = m_p2 ^ AL;
            in_pressed = m_level && (m_run == 0);
            if (in_pressed) begin
                m_hold++;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
                if (m_hold == L) e_long = 1;
`endif
            end
            if (s != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = s;
                    m_run = 0;
                    m_hold = 0;
                    if (s) e_press = 1;
                    else e_release = 1;
                end
            end else begin
                m_run = 0;
            end
            m_p2 = m_p1;
            m_p1 = b;
        end
        #1;
        chk("btn_level", btn_level, m_level);
        chk("press_pulse", press_pulse, e_press);
        chk("release_pulse", release_pulse, e_release);
        chk("long_press", long_press, e_long);
        chk("pulse_exclusive", press_pulse & release_pulse, 1'b0);
        if (press_pulse === 1'b1) press_seen++;
        if (release_pulse === 1'b1) release_seen++;
        if (long_press === 1'b1) long_seen++;
    endtask

    task automatic hold(input bit v, input int n);
        btn_in = v;
        repeat (n) step();
    endtask

    initial begin
        int p0, r0, l0, exp_long;
        bit v;
        rst = 1'b1;
        btn_in = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        hold(1'b1, 20);
        chk_int("idle_no_pulses", press_seen + release_seen + long_seen, 0);

        // Clean press and release.
        p0 = press_seen; r0 = release_seen;
        hold(1'b0, 12);
        hold(1'b1, 12);
        chk_int("clean_press_count", press_seen - p0, 1);
        chk_int("clean_release_count", release_seen - r0, 1);

        // Bouncing press: glitches shorter than D, then a real hold.
        p0 = press_seen;
        repeat (5) begin
            hold(1'b0, 3);
            hold(1'b1, 2);
        end
        chk_int("glitch_no_press", press_seen - p0, 0);
        hold(1'b0, 10);
        hold(1'b1, 12);
        chk_int("bounce_one_press", press_seen - p0, 1);

        // Short release glitch while pressed.
        r0 = release_seen;
        hold(1'b0, 10);
        hold(1'b1, 2);
        hold(1'b0, 10);
        chk_int("release_glitch_none", release_seen - r0, 0);
        hold(1'b1, 12);

        // Reset mid-press with button held.
        hold(1'b0, 10);
        p0 = press_seen; r0 = release_seen;
        rst = 1'b1;
        step();
        rst = 1'b0;
        hold(1'b0, 12);
        chk_int("rst_press_again", press_seen - p0, 1);
        chk_int("rst_no_release", release_seen - r0, 0);
        hold(1'b1, 12);

        // Long hold.
        l0 = long_seen;
        hold(1'b0, 30);
        hold(1'b1, 12);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        exp_long = 1;
`else
        exp_long = 0;
`endif
        chk_int("long_hold_count", long_seen - l0, exp_long);

        // Randomized bouncing with occasional reset.
        repeat (300) begin
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            v = 1'($urandom_range(0, 1));
            hold(v, $urandom_range(1, 14));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
